// File: rtl/param_load_counter.sv
// param_load_counter: parametrised up/down counter with synchronous load,
// count enable and four boundary modes (wrap, reload-from-base, saturate,
// one-shot). The last loaded value is kept as a restart base, and a
// registered terminal-count pulse marks every boundary step.
//
// Optional feature: define COUNTER_WRAP_COUNT_EN to add the 8-bit output
// wrap_cnt_o, a saturating count of boundary events since the last reset
// or load. Without the macro the port and its logic are absent.
module param_load_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = 2**WIDTH - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
`ifdef COUNTER_WRAP_COUNT_EN
  output logic [7:0]       wrap_cnt_o,
`endif
  output logic             done_o
);

  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_SAT     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_e;

  state_e           state;
  mode_e            mode;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] load_val;
  logic             tc;
  logic             done;
  logic             at_bound;
  logic             step;
`ifdef COUNTER_WRAP_COUNT_EN
  logic [7:0]       wrap_cnt;
`endif

  // Loads never place a value above the top count, so no overflow path exists.
  assign load_val = (load_val_i > MAX) ? MAX : load_val_i;

  // A boundary is an up step at the top value or a down step at zero; a step
  // in the opposite direction from a boundary value is an ordinary step.
  assign at_bound = up_i ? (count == MAX) : (count == ZERO);
  assign step     = en_i && (state == RUN);
  assign mode     = mode_e'(mode_i);

  // Single state register: reset beats load, load beats step, DONE freezes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RST;
      base  <= RST;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
`ifdef COUNTER_WRAP_COUNT_EN
      wrap_cnt <= 8'd0;
`endif
    end else if (load_i) begin
      count <= load_val;
      base  <= load_val;
      tc    <= 1'b0;
      done  <= 1'b0;
      state <= RUN;
`ifdef COUNTER_WRAP_COUNT_EN
      wrap_cnt <= 8'd0;
`endif
    end else if (step) begin
      if (!at_bound) begin
        count <= up_i ? (count + 1'b1) : (count - 1'b1);
        tc    <= 1'b0;
      end else begin
        tc <= 1'b1;
`ifdef COUNTER_WRAP_COUNT_EN
        if (wrap_cnt != 8'hFF) begin
          wrap_cnt <= wrap_cnt + 8'd1;
        end
`endif
        case (mode)
          MODE_WRAP:    count <= up_i ? ZERO : MAX;
          MODE_RELOAD:  count <= base;
          MODE_SAT:     count <= count;
          MODE_ONESHOT: begin
            count <= count;
            state <= DONE;
            done  <= 1'b1;
          end
          default:      count <= count;
        endcase
      end
    end else begin
      tc <= 1'b0;
    end
  end

  assign count_o = count;
  assign tc_o    = tc;
  assign done_o  = done;
`ifdef COUNTER_WRAP_COUNT_EN
  assign wrap_cnt_o = wrap_cnt;
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// tb_param_load_counter: scoreboard bench for param_load_counter with
// WIDTH=4, MAX_VAL=9, RESET_VAL=0. Stimulus pushes hand-computed expected
// outputs into a queue; an independent monitor pops and compares them.
// Also exercises wrap_cnt_o when COUNTER_WRAP_COUNT_EN is defined.
module tb_param_load_counter;

  localparam logic [1:0] WRAP    = 2'b00;
  localparam logic [1:0] RELOAD  = 2'b01;
  localparam logic [1:0] SAT     = 2'b10;
  localparam logic [1:0] ONESHOT = 2'b11;

  logic       clk;
  logic       reset;
  logic       load_i;
  logic [3:0] load_val_i;
  logic       en_i;
  logic       up_i;
  logic [1:0] mode_i;
  logic [3:0] count_o;
  logic       tc_o;
  logic       done_o;
`ifdef COUNTER_WRAP_COUNT_EN
  logic [7:0] wrap_cnt_o;
`endif

  typedef struct {
    logic [3:0] count;
    logic       tc;
    logic       done;
    int         wrap;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  param_load_counter #(
    .WIDTH(4),
    .MAX_VAL(9),
    .RESET_VAL(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_i(load_i),
    .load_val_i(load_val_i),
    .en_i(en_i),
    .up_i(up_i),
    .mode_i(mode_i),
    .count_o(count_o),
    .tc_o(tc_o),
`ifdef COUNTER_WRAP_COUNT_EN
    .wrap_cnt_o(wrap_cnt_o),
`endif
    .done_o(done_o)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one expected entry against the settled DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic ok;
    ok = (count_o === e.count) && (tc_o === e.tc) && (done_o === e.done);
`ifdef COUNTER_WRAP_COUNT_EN
    if (e.wrap >= 0 && wrap_cnt_o !== 8'(e.wrap)) ok = 1'b0;
`endif
    checks++;
    if (ok) begin
      passes++;
    end else begin
`ifdef COUNTER_WRAP_COUNT_EN
      $display("[TB] FAIL %s: got count=%0d tc=%0b done=%0b wrap=%0d, expected count=%0d tc=%0b done=%0b wrap=%0d",
               e.name, count_o, tc_o, done_o, wrap_cnt_o, e.count, e.tc, e.done, e.wrap);
`else
      $display("[TB] FAIL %s: got count=%0d tc=%0b done=%0b, expected count=%0d tc=%0b done=%0b",
               e.name, count_o, tc_o, done_o, e.count, e.tc, e.done);
`endif
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] val,
                               input logic en, input logic up, input logic [1:0] mode,
                               input logic [3:0] ec, input logic etc, input logic ed,
                               input int ew, input string name);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    load_i     = ld;
    load_val_i = val;
    en_i       = en;
    up_i       = up;
    mode_i     = mode;
    @(posedge clk);
    e.count = ec;
    e.tc    = etc;
    e.done  = ed;
    e.wrap  = ew;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    reset = 1'b1; load_i = 1'b0; load_val_i = 4'd0;
    en_i = 1'b0; up_i = 1'b1; mode_i = WRAP;

    // 1. reset held, then WRAP up count 1..9,0,1,2
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 0, 0, 0, 1, WRAP, 4'd0, 0, 0, 0, "reset_hold");
    for (int v = 1; v <= 9; v++)
      applyStimulus(0, 0, 0, 1, 1, WRAP, 4'(v), 0, 0, -1, "wrap_up");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd0, 1, 0, -1, "wrap_up_boundary");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd1, 0, 0, -1, "wrap_up_after");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd2, 0, 0, -1, "wrap_up_after");

    // 2. load 4 then RELOAD up, clamp of 13
    applyStimulus(0, 1, 4'd4, 0, 1, RELOAD, 4'd4, 0, 0, 0, "load4");
    for (int v = 5; v <= 9; v++)
      applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'(v), 0, 0, -1, "reload_up");
    applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'd4, 1, 0, -1, "reload_boundary");
    applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'd5, 0, 0, -1, "reload_after");
    applyStimulus(0, 1, 4'd13, 0, 1, RELOAD, 4'd9, 0, 0, 0, "load_clamp13");

    // 3. down counting: WRAP then SAT
    applyStimulus(0, 1, 4'd2, 0, 0, WRAP, 4'd2, 0, 0, 0, "load2");
    applyStimulus(0, 0, 0, 1, 0, WRAP, 4'd1, 0, 0, -1, "wrap_down");
    applyStimulus(0, 0, 0, 1, 0, WRAP, 4'd0, 0, 0, -1, "wrap_down");
    applyStimulus(0, 0, 0, 1, 0, WRAP, 4'd9, 1, 0, -1, "wrap_down_boundary");
    applyStimulus(0, 0, 0, 1, 0, WRAP, 4'd8, 0, 0, -1, "wrap_down_after");
    applyStimulus(0, 1, 4'd2, 0, 0, SAT, 4'd2, 0, 0, 0, "load2_sat");
    applyStimulus(0, 0, 0, 1, 0, SAT, 4'd1, 0, 0, -1, "sat_down");
    applyStimulus(0, 0, 0, 1, 0, SAT, 4'd0, 0, 0, -1, "sat_down");
    applyStimulus(0, 0, 0, 1, 0, SAT, 4'd0, 1, 0, -1, "sat_hold_tc");
    applyStimulus(0, 0, 0, 1, 0, SAT, 4'd0, 1, 0, -1, "sat_hold_tc");
    applyStimulus(0, 0, 0, 1, 1, SAT, 4'd1, 0, 0, -1, "sat_reverse_step");

    // 4. ONESHOT: finish, ignore en and mode change, load restarts
    applyStimulus(0, 1, 4'd7, 0, 1, ONESHOT, 4'd7, 0, 0, 0, "load7");
    applyStimulus(0, 0, 0, 1, 1, ONESHOT, 4'd8, 0, 0, -1, "oneshot_up");
    applyStimulus(0, 0, 0, 1, 1, ONESHOT, 4'd9, 0, 0, -1, "oneshot_up");
    applyStimulus(0, 0, 0, 1, 1, ONESHOT, 4'd9, 1, 1, -1, "oneshot_done");
    applyStimulus(0, 0, 0, 1, 1, ONESHOT, 4'd9, 0, 1, -1, "done_hold");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd9, 0, 1, -1, "done_mode_change");
    applyStimulus(0, 0, 0, 1, 0, WRAP, 4'd9, 0, 1, -1, "done_dir_change");
    applyStimulus(0, 1, 4'd3, 0, 1, WRAP, 4'd3, 0, 0, 0, "load3_exit_done");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd4, 0, 0, -1, "resume");
    applyStimulus(0, 0, 0, 1, 1, WRAP, 4'd5, 0, 0, -1, "resume");

    // 5. load beats en, load held, clamp while held, en low holds
    applyStimulus(0, 1, 4'd1, 1, 1, WRAP, 4'd1, 0, 0, 0, "load_over_en");
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1, 4'd9, 1, 1, WRAP, 4'd9, 0, 0, 0, "load_held9");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 4'd13, 1, 1, SAT, 4'd9, 0, 0, 0, "load_held13");
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 0, 0, 1, WRAP, 4'd9, 0, 0, -1, "en_low_hold");

    // 6. reset mid-RELOAD, base returns to 0, wrap counter
    applyStimulus(0, 1, 4'd4, 0, 1, RELOAD, 4'd4, 0, 0, 0, "load4_again");
    applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'd5, 0, 0, -1, "reload_up");
    applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'd6, 0, 0, -1, "reload_up");
    applyStimulus(1, 0, 0, 1, 1, RELOAD, 4'd0, 0, 0, 0, "reset_mid_count");
    for (int w = 0; w < 3; w++) begin
      for (int v = 1; v <= 9; v++)
        applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'(v), 0, 0, w, "reload_from_zero");
      applyStimulus(0, 0, 0, 1, 1, RELOAD, 4'd0, 1, 0, w + 1, "reload_base0_boundary");
    end
    applyStimulus(0, 0, 0, 0, 1, RELOAD, 4'd0, 0, 0, 3, "wrap_cnt_hold");

    // Wait (bounded) for the monitor to drain the scoreboard.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/param_load_counter.md
Name: param_load_counter

Overview:
Parametrised up/down counter with synchronous load, count enable, and four boundary modes: wrap, reload-from-last-loaded, saturate and one-shot. It keeps the last loaded value as a restart base and flags terminal-count events. It serves as the general counting primitive for timers, pacing and sequence indexing.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, top count value, inclusive; legal range 1..2**WIDTH-1
RESET_VAL, 0, value of count and base after reset; must be <= MAX_VAL

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
load_i  input  1  load load_val_i into count and base
load_val_i  input  WIDTH  value to load
en_i  input  1  step enable
up_i  input  1  direction: 1 = increment, 0 = decrement
mode_i  input  2  boundary mode: 00 WRAP, 01 RELOAD, 10 SAT, 11 ONESHOT
count_o  output  WIDTH  current count, registered
tc_o  output  1  terminal-count pulse, registered
done_o  output  1  ONESHOT finished, registered

Behaviour:
- Reset (clk edge with reset=1):
  - count_o=RESET_VAL, base=RESET_VAL, tc_o=0, done_o=0, state=RUN.
- Priority per edge: reset > load_i > step.
- Load:
  - Loaded value = min(load_val_i, MAX_VAL).
  - count_o and base take the loaded value on the next edge; tc_o=0, done_o=0, state=RUN.
  - Load ignores en_i and mode_i.
  - load_i held high keeps count_o at the loaded value every cycle.
- Step occurs when en_i=1, load_i=0 and state=RUN. Latency is 1 cycle (count_o updates on the same edge).
  - Up step, count_o<MAX_VAL: count_o+1.
  - Down step, count_o>0: count_o-1.
  - Boundary = up step at MAX_VAL, or down step at 0.
- Boundary action by mode_i sampled that cycle:
  - WRAP: up goes to 0, down goes to MAX_VAL.
  - RELOAD: goes to base. Base is not altered by stepping.
  - SAT: count holds.
  - ONESHOT: count holds, state goes to DONE, done_o=1.
- tc_o:
  - 1 for exactly the cycle following each boundary step, otherwise 0.
  - In SAT, tc_o stays 1 on every enabled cycle at the boundary.
- States: RUN and DONE.
  - RUN -> DONE only on an ONESHOT boundary step.
  - DONE -> RUN only on load or reset.
  - In DONE, en_i is ignored, count_o holds and tc_o=0. Changing mode_i does not exit DONE.
- Mode and direction changes:
  - mode_i and up_i may change on any cycle; the new values apply to the next step.
  - A direction reversal at a boundary value is a normal step away from it, not a boundary.
- en_i=0 holds count_o; tc_o=0.
- No arithmetic overflow paths: count_o is never > MAX_VAL.
- Reset asserted mid-count or in DONE overrides everything on that edge.

Optional Feature:
Macro COUNTER_WRAP_COUNT_EN.
- Defined:
  - Adds output wrap_cnt_o, 8 bits: number of boundary events since the last reset or load.
  - Saturates at 255. Cleared by reset and by load.
  - Increments on the same edge that tc_o is set.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use WIDTH=4, MAX_VAL=9, RESET_VAL=0.
1. Reset then release:
   - Reset high 12 cycles -> count_o=0, tc_o=0, done_o=0.
   - WRAP, up, en held 12 cycles -> 1..9,0,1,2; tc_o high one cycle after the 9->0 step.
2. Load and RELOAD mode:
   - load_val_i=4 for one cycle, then RELOAD, up, en -> 4,5..9,4,5; tc_o pulses after each 9->4 step.
   - Load 13 -> clamps to 9.
3. Down counting:
   - Load 2, WRAP, up_i=0, en -> 2,1,0,9,8.
   - Same with SAT -> 2,1,0,0,0; tc_o high for each cycle held at 0.
4. ONESHOT:
   - Load 7, up, en -> 8,9,9; done_o=1 from the edge after the 9-boundary step.
   - Further en and a switch to WRAP -> count_o stays 9, done_o stays 1.
   - Load 3 -> done_o=0, counting resumes.
5. Priority and holds:
   - load_i and en_i together at count 5 with load_val_i=1 -> count_o=1.
   - load_i held 20 cycles with value 9 -> count_o constant 9.
   - Change load_val_i to 13 while held -> 9 (clamped).
   - en_i=0 -> count_o holds.
6. Reset mid-operation:
   - Reset asserted while at count 6 in RELOAD with base 4 -> count_o=0, base=0.
   - A later RELOAD boundary goes to 0.
   - With COUNTER_WRAP_COUNT_EN: wrap_cnt_o=0 after reset and counts 3 after 3 wraps.
